// File: rtl/rr_burst_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_burst_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority encoder: first unmasked request at or after ptr, wrapping.
module rr_priority_pick
  import rr_burst_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          mask,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic                  found,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int IW = idx_w(N);

  logic [N-1:0] elig_s;

  assign elig_s = req & ~mask;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (elig_s[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-way round-robin arbiter that holds a grant for the whole burst.
// Optional burst limit forcing rotation: define RR_BURST_ARB_LIMIT_EN.
module rr_burst_arbiter
  import rr_burst_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        requests,
  output logic [N-1:0]        grants,
  output logic [idx_w(N)-1:0] grant_idx,
  output logic                busy
);

  localparam int IW = idx_w(N);

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   grants_q, grants_d;
  logic [IW-1:0]  gidx_q, gidx_d;
  logic           busy_q, busy_d;

  logic [IW-1:0]  nxt_ptr_s;
  logic [IW-1:0]  pick_ptr_s;
  logic [N-1:0]   mask_s;
  logic [N-1:0]   owner_oh_s;
  logic [N-1:0]   win_oh_s;
  logic           found_s;
  logic [IW-1:0]  pick_idx_s;

`ifdef RR_BURST_ARB_LIMIT_EN
  localparam int BW = idx_w(MAX_BURST);
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
`else
  logic           cfg_unused_s;
  assign cfg_unused_s = (MAX_BURST > 1);
`endif

  assign nxt_ptr_s  = (gidx_q == IW'(N - 1)) ? {IW{1'b0}} : gidx_q + IW'(1);
  assign owner_oh_s = {{(N-1){1'b0}}, 1'b1} << gidx_q;
  assign win_oh_s   = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;

  // While granting, arbitration always starts after the owner and skips it.
  always_comb begin
    pick_ptr_s = ptr_q;
    mask_s     = '0;
    if (state_q == ST_GRANT) begin
      pick_ptr_s = nxt_ptr_s;
      mask_s     = owner_oh_s;
    end else begin
      pick_ptr_s = ptr_q;
      mask_s     = '0;
    end
  end

  rr_priority_pick #(.N(N)) u_pick (
    .req   (requests),
    .mask  (mask_s),
    .ptr   (pick_ptr_s),
    .found (found_s),
    .idx   (pick_idx_s)
  );

  // Next-state and next-grant decision.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grants_d = grants_q;
    gidx_d   = gidx_q;
`ifdef RR_BURST_ARB_LIMIT_EN
    burst_cnt_d = burst_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d  = ST_GRANT;
          grants_d = win_oh_s;
          gidx_d   = pick_idx_s;
`ifdef RR_BURST_ARB_LIMIT_EN
          burst_cnt_d = '0;
`endif
        end else begin
          grants_d = '0;
          gidx_d   = '0;
        end
      end
      ST_GRANT: begin
        if (requests[gidx_q]) begin
`ifdef RR_BURST_ARB_LIMIT_EN
          if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
            // Tenure exhausted: hand over only if someone else is waiting.
            if (found_s) begin
              ptr_d       = nxt_ptr_s;
              grants_d    = win_oh_s;
              gidx_d      = pick_idx_s;
              burst_cnt_d = '0;
            end else begin
              burst_cnt_d = burst_cnt_q;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
`else
          grants_d = grants_q;
`endif
        end else begin
          ptr_d = nxt_ptr_s;
          if (found_s) begin
            grants_d = win_oh_s;
            gidx_d   = pick_idx_s;
`ifdef RR_BURST_ARB_LIMIT_EN
            burst_cnt_d = '0;
`endif
          end else begin
            state_d  = ST_IDLE;
            grants_d = '0;
            gidx_d   = '0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grants_d = '0;
        gidx_d   = '0;
      end
    endcase
  end

  assign busy_d = |grants_d;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grants_q <= '0;
      gidx_q   <= '0;
      busy_q   <= 1'b0;
`ifdef RR_BURST_ARB_LIMIT_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grants_q <= grants_d;
      gidx_q   <= gidx_d;
      busy_q   <= busy_d;
`ifdef RR_BURST_ARB_LIMIT_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign grants    = grants_q;
  assign grant_idx = gidx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (N=4, MAX_BURST=4); expectations follow RR_BURST_ARB_LIMIT_EN.
module tb_rr_burst_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] requests;
  logic [3:0] grants;
  logic [1:0] grant_idx;
  logic       busy;

  int n_checks;
  int n_fail;

  rr_burst_arbiter #(.N(4), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .requests  (requests),
    .grants    (grants),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] i, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.g = g; v.idx = i; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then check all outputs just after the edge.
  task automatic step(input string name, input int cyc, input logic r, input logic [3:0] q,
                      input logic [3:0] g, input logic [1:0] i);
    rst      = r;
    requests = q;
    @(posedge clk);
    #1;
    chk({name, ".grants"}, cyc, grants, g);
    chk({name, ".idx"}, cyc, {2'b00, grant_idx}, {2'b00, i});
    chk({name, ".busy"}, cyc, {3'b000, busy}, {3'b000, (g != 4'b0000)});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    requests = 4'b1111;

    // reset, rotation, long burst, pointer wrap
    tbl[0]  = mk(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    tbl[1]  = mk(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    tbl[2]  = mk(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    tbl[3]  = mk(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1);
    tbl[4]  = mk(1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1);
    tbl[5]  = mk(1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1);
    tbl[6]  = mk(1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1);
    tbl[7]  = mk(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    for (int k = 8; k <= 16; k++) tbl[k] = mk(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    tbl[17] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    tbl[18] = mk(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
    tbl[19] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    tbl[20] = mk(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
    tbl[21] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    for (int v = 0; v < NV; v++)
      step("table", v, tbl[v].rst, tbl[v].req, tbl[v].g, tbl[v].idx);

    // Burst limit: move ptr to 0 via requester 3, then hold 0011 with requester 0 owning.
    step("limit_setup", 0, 1'b0, 4'b1000, 4'b1000, 2'd3);
    step("limit_setup", 1, 1'b0, 4'b0000, 4'b0000, 2'd0);
`ifdef RR_BURST_ARB_LIMIT_EN
    for (int c = 0; c < 4; c++) step("limit", c, 1'b0, 4'b0011, 4'b0001, 2'd0);
    for (int c = 4; c < 8; c++) step("limit", c, 1'b0, 4'b0011, 4'b0010, 2'd1);
    step("limit", 8, 1'b0, 4'b0011, 4'b0001, 2'd0);
`else
    for (int c = 0; c < 9; c++) step("nolimit", c, 1'b0, 4'b0011, 4'b0001, 2'd0);
`endif
    step("limit_tail", 0, 1'b0, 4'b0010, 4'b0010, 2'd1);
    step("limit_tail", 1, 1'b0, 4'b0000, 4'b0000, 2'd0);

    // Reset mid-grant, then arbitration restarts from ptr 0.
    step("rst_mid", 0, 1'b0, 4'b0100, 4'b0100, 2'd2);
    step("rst_mid", 1, 1'b0, 4'b0100, 4'b0100, 2'd2);
    step("rst_mid", 2, 1'b1, 4'b0100, 4'b0000, 2'd0);
    step("rst_mid", 3, 1'b0, 4'b1100, 4'b0100, 2'd2);
    step("rst_mid", 4, 1'b0, 4'b1000, 4'b1000, 2'd3);
    step("rst_mid", 5, 1'b0, 4'b0000, 4'b0000, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

N-way round-robin arbiter that shares one multi-cycle downstream resource (bus, memory port, shared ALU) between N requesters. A winner keeps its grant for as long as it holds its request, so bursts are never split. The next winner is chosen in rotating priority, starting after the previous winner. An optional burst limit forces rotation so a long-holding requester cannot starve the others.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `MAX_BURST`, default 8: maximum consecutive grant cycles per tenure, MAX_BURST ≥ 2. Used only with `RR_BURST_ARB_LIMIT_EN`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `requests`, input, N: bit i high means requester i wants, or is still using, the resource.
- `grants`, output, N: registered, one-hot or zero; bit i means requester i owns the resource this cycle.
- `grant_idx`, output, $clog2(N): binary index of the granted requester; 0 when `grants` is 0.
- `busy`, output, 1: registered; equals |grants.

## Operation
- State machine with two states, `ST_IDLE` and `ST_GRANT`, held in state register `state`. Other internal registers:
  - `ptr`: priority pointer, $clog2(N) bits.
  - `burst_cnt`: cycle counter, $clog2(MAX_BURST) bits.
- **ST_IDLE**
  - No requests: stay in `ST_IDLE`.
  - Any request: pick the first set bit of `requests` at index `ptr`, `ptr`+1, … `N`-1, 0, …, wrapping mod N.
  - Register that bit as the grant; go to `ST_GRANT`; clear `burst_cnt`.
- **ST_GRANT**, owner index `g`:
  - `requests[g]` high: keep the grant; `burst_cnt` increments, saturating at MAX_BURST-1.
  - `requests[g]` low (release): set `ptr` = (g+1) mod N, then re-arbitrate in the same cycle.
    - Another request pending: the new winner is granted on the next edge. There is no idle cycle between tenures.
    - No request pending: go to `ST_IDLE`; `grants` drops to 0.
- Non-owner request bits never affect the current grant. The grant is only ever issued to a requester whose request bit is high in the deciding cycle.
- A requester that drops its request and raises it again in the next cycle is a new contender and goes through normal arbitration.

## Timing
- Reset values: `grants`=0, `grant_idx`=0, `busy`=0, `state`=`ST_IDLE`, `ptr`=0, `burst_cnt`=0. `rst` overrides all other activity, including mid-grant; the grant drops on the next edge.
- Request-to-grant latency is 1 cycle: a request sampled high at edge t produces the grant after edge t (visible in cycle t+1).
- Release-to-regrant latency is 1 cycle: owner low in cycle t gives the old grant low and the new grant high in cycle t+1.
- All outputs are registered; there is no combinational path from `requests` to `grants`.
- Simultaneous release and new requests: new requests are visible to that same arbitration.

## Configuration
- `RR_BURST_ARB_LIMIT_EN` defined:
  - In `ST_GRANT`, when `burst_cnt` == MAX_BURST-1 (the owner has held the grant for MAX_BURST cycles) and any other request bit is high, the owner is preempted.
  - On preemption: `ptr` = (g+1) mod N, and a re-arbitration that excludes `g` issues the new grant on the next edge.
  - If no other request is pending, the owner keeps the grant and `burst_cnt` holds at MAX_BURST-1.
- `RR_BURST_ARB_LIMIT_EN` undefined:
  - The owner keeps the grant until it releases, with no time limit.
  - `burst_cnt` and its logic are not compiled in.

## Structure
- Package `rr_burst_arb_pkg` holds:
  - the `state_t` enum (`ST_IDLE`, `ST_GRANT`);
  - the index width function `idx_w(N)`.
- Sub-module `rr_priority_pick`: a combinational rotating-priority encoder with inputs `req[N]`, `mask[N]` and `ptr`, and outputs `found` and `idx`.
  - It is instantiated once.
  - `mask` excludes the current owner during preemption.
- The top level holds the state register, `ptr`, `burst_cnt` and the output registers.

## Test plan
All scenarios use N=4, MAX_BURST=4.
- **Reset:** `rst`=1 for 2 cycles with `requests`=4'b1111 → `grants`=0 and `busy`=0. First edge with `rst`=0 → `grants`=4'b0001, `grant_idx`=0.
- **Rotation:** all four request; each owner drops its request for exactly 1 cycle after being granted → `grants` sequence 0001, 0010, 0100, 1000, 0001 with no zero cycles between.
- **Long single burst:** `requests`=4'b0100 for 10 cycles, then 0 → `grants`=0100 for 10 cycles (with or without the macro), then 0 one cycle after the drop; `busy` tracks `grants`.
- **Pointer wrap:** requester 1 is granted and then releases (`ptr`=2); next `requests`=4'b0011 → `grants`=4'b0001.
- **Burst limit:** `requests`=4'b0011 held, requester 0 owns.
  - With `RR_BURST_ARB_LIMIT_EN`: `grants`=0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
  - Without the macro: 0001 until `requests[0]` drops.
- **Reset mid-grant:** `rst` pulses high while `grants`=4'b0100 → `grants`=0 after that edge. After release with `requests`=4'b1100 → `grants`=4'b0100 (`ptr` reset to 0).
